// File: rtl/stage_mdu.sv
// stage_mdu: multi-cycle multiply/divide unit owning HI/LO for the execute stage.
// Results are computed at launch and held in pending until the busy window ends.
module stage_mdu #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             cancel,
  output logic             busy,
  output logic             mdu_stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int MAX_CYCLES = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_next;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] pending, acc, a_ext, b_ext, prod, result;
  logic [WIDTH-1:0] abs_a, abs_b, den, q_mag, r_mag, quo, rem;
  logic is_md, is_div, is_signed, take, launch, last, done, wr_hi, wr_lo;
  always_comb begin
    is_md     = op >= 4'd1 && op <= 4'd8;
    is_div    = op == 4'd3 || op == 4'd4;
    is_signed = is_md && op[0];
    take      = state == IDLE && start && !cancel;
    launch    = take && is_md;
    wr_hi     = take && op == 4'd9;
    wr_lo     = take && op == 4'd10;
    last      = cnt == CW'(1);
    done      = state == RUN && last && !cancel;
  end
  // Divide on magnitudes so the most-negative / -1 case wraps to itself with zero remainder.
  always_comb begin
    acc    = {hi, lo};
    a_ext  = is_signed ? {{WIDTH{rs_data[WIDTH-1]}}, rs_data} : {{WIDTH{1'b0}}, rs_data};
    b_ext  = is_signed ? {{WIDTH{rt_data[WIDTH-1]}}, rt_data} : {{WIDTH{1'b0}}, rt_data};
    prod   = a_ext * b_ext;
    abs_a  = is_signed && rs_data[WIDTH-1] ? -rs_data : rs_data;
    abs_b  = is_signed && rt_data[WIDTH-1] ? -rt_data : rt_data;
    den    = abs_b == '0 ? WIDTH'(1) : abs_b;
    q_mag  = abs_a / den;
    r_mag  = abs_a % den;
    quo    = is_signed && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]) ? -q_mag : q_mag;
    rem    = is_signed && rs_data[WIDTH-1] ? -r_mag : r_mag;
    result = is_div ? (rt_data == '0 ? acc : {rem, quo}) :
             (op == 4'd5 || op == 4'd6) ? acc + prod :
             (op == 4'd7 || op == 4'd8) ? acc - prod : prod;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state == IDLE ? (launch ? RUN : IDLE) : (cancel || last ? IDLE : RUN);
  end
  always_comb begin
    busy      = state == RUN;
    mdu_stall = busy || (start && is_md);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      pending <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      if (launch) begin
        pending <= result;
        cnt     <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (state == RUN) cnt <= cancel || last ? '0 : cnt - CW'(1);
      if (done) begin
        hi <= pending[2*WIDTH-1:WIDTH];
        lo <= pending[WIDTH-1:0];
      end
      if (wr_hi) hi <= rs_data;
      if (wr_lo) lo <= rs_data;
    end
  end
endmodule

// File: tb/tb_stage_mdu.sv
// tb_stage_mdu: scoreboard bench for stage_mdu; default latencies plus a 1/1-cycle instance.
module tb_stage_mdu;
  logic clk = 1'b0;
  logic reset, start, cancel, start1, cancel1;
  logic [3:0] op, op1;
  logic [31:0] rs_data, rt_data, rs1, rt1;
  logic busy, mdu_stall, busy1, stall1;
  logic [31:0] hi, lo, hi1, lo1;
  logic [63:0] sb_q[$];
  logic [63:0] mhl;
  int vectors = 0;
  int errors = 0;

  stage_mdu u0 (.clk(clk), .reset(reset), .start(start), .op(op), .rs_data(rs_data),
    .rt_data(rt_data), .cancel(cancel), .busy(busy), .mdu_stall(mdu_stall), .hi(hi), .lo(lo));
  stage_mdu #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)) u1 (.clk(clk), .reset(reset),
    .start(start1), .op(op1), .rs_data(rs1), .rt_data(rt1), .cancel(cancel1), .busy(busy1),
    .mdu_stall(stall1), .hi(hi1), .lo(lo1));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] acc);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] ps, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ps = sa * sb;
    pu = ua * ub;
    case (o)
      4'd1: return ps;
      4'd2: return pu;
      4'd3: begin
        if (b == 0) return acc;
        return {32'(sa % sb), 32'(sa / sb)};
      end
      4'd4: begin
        if (b == 0) return acc;
        return {a % b, a / b};
      end
      4'd5: return acc + ps;
      4'd6: return acc + pu;
      4'd7: return acc - ps;
      4'd8: return acc - pu;
      default: return acc;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_md(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    int n;
    logic stall_ok;
    logic [63:0] exp_v;
    sb_q.push_back(model(o, a, b, mhl));
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    #1;
    vectors++;
    if (mdu_stall !== 1'b1) begin
      errors++;
      $display("FAIL stall_start op=%0d: got %b want 1", o, mdu_stall);
    end
    tick();
    start = 1'b0; op = 4'd0;
    n = 0;
    stall_ok = 1'b1;
    while (busy === 1'b1 && n < 200) begin
      if (mdu_stall !== 1'b1) stall_ok = 1'b0;
      n++;
      tick();
    end
    vectors++;
    if (n != ((o == 4'd3 || o == 4'd4) ? 10 : 5)) begin
      errors++;
      $display("FAIL busy_cycles op=%0d: got %0d want %0d", o, n, (o == 4'd3 || o == 4'd4) ? 10 : 5);
    end
    vectors++;
    if (stall_ok !== 1'b1) begin
      errors++;
      $display("FAIL stall_busy op=%0d: got 0 want 1 in every busy cycle", o);
    end
    exp_v = sb_q.pop_front();
    vectors++;
    if ({hi, lo} !== exp_v) begin
      errors++;
      $display("FAIL result op=%0d a=%h b=%h: got %h_%h want %h", o, a, b, hi, lo, exp_v);
    end
    mhl = exp_v;
  endtask

  task automatic mt(input logic [3:0] o, input logic [31:0] v);
    op = o; rs_data = v; start = 1'b1;
    #1;
    vectors++;
    if (mdu_stall !== 1'b0) begin
      errors++;
      $display("FAIL mt_stall op=%0d: got %b want 0", o, mdu_stall);
    end
    tick();
    start = 1'b0; op = 4'd0;
    if (o == 4'd9) mhl[63:32] = v;
    else mhl[31:0] = v;
    vectors++;
    if ({busy, hi, lo} !== {1'b0, mhl}) begin
      errors++;
      $display("FAIL mt_write op=%0d: got busy=%b %h_%h want busy=0 %h", o, busy, hi, lo, mhl);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; cancel = 1'b0; op = 4'd0; rs_data = '0; rt_data = '0;
    start1 = 1'b0; cancel1 = 1'b0; op1 = 4'd0; rs1 = '0; rt1 = '0;
    mhl = '0;
    #12;
    vectors++;
    if ({busy, mdu_stall, hi, lo, busy1, hi1, lo1} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b stall=%b %h_%h u1 busy=%b %h_%h want all 0",
               busy, mdu_stall, hi, lo, busy1, hi1, lo1);
    end
    reset = 1'b0;
    tick();
    mt(4'd9, 32'h11);
    mt(4'd10, 32'h22);
    op = 4'd3; rs_data = 32'd100; rt_data = 32'd7; start = 1'b1;
    tick();
    start = 1'b0; op = 4'd0;
    repeat (3) tick();
    reset = 1'b1;
    #1;
    vectors++;
    if ({busy, hi, lo} !== '0) begin
      errors++;
      $display("FAIL reset_async: got busy=%b %h_%h want busy=0 0_0", busy, hi, lo);
    end
    tick();
    reset = 1'b0;
    mhl = '0;
    repeat (12) tick();
    vectors++;
    if ({busy, hi, lo} !== '0) begin
      errors++;
      $display("FAIL reset_no_update: got busy=%b %h_%h want busy=0 0_0", busy, hi, lo);
    end
  endtask

  task automatic test_mult();
    run_md(4'd1, 32'hFFFF_FFFE, 32'd3);
    run_md(4'd2, 32'hFFFF_FFFE, 32'd3);
    run_md(4'd1, 32'h8000_0000, 32'h8000_0000);
  endtask

  task automatic test_div();
    run_md(4'd3, 32'hFFFF_FFF9, 32'd2);
    run_md(4'd4, 32'hFFFF_FFF9, 32'd2);
    run_md(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    run_md(4'd3, 32'd7, 32'hFFFF_FFFE);
    mt(4'd9, 32'd5);
    mt(4'd10, 32'd6);
    run_md(4'd3, 32'd1234, 32'd0);
    run_md(4'd4, 32'd1234, 32'd0);
  endtask

  task automatic test_madd();
    mt(4'd9, 32'd0);
    mt(4'd10, 32'hFFFF_FFFF);
    run_md(4'd5, 32'd1, 32'd1);
    mt(4'd9, 32'd0);
    mt(4'd10, 32'd1);
    run_md(4'd8, 32'd1, 32'd2);
    run_md(4'd7, 32'hFFFF_FFFF, 32'd3);
    run_md(4'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
  endtask

  task automatic test_random();
    logic [3:0] o;
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      o = 4'($urandom_range(1, 8));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      run_md(o, a, b);
    end
  endtask

  task automatic test_overlap();
    int n;
    logic [63:0] exp_v;
    sb_q.push_back(model(4'd1, 32'd7, 32'd6, mhl));
    op = 4'd1; rs_data = 32'd7; rt_data = 32'd6; start = 1'b1;
    tick();
    start = 1'b0; op = 4'd0;
    tick();
    op = 4'd10; rs_data = 32'hDEAD_BEEF; start = 1'b1;
    #1;
    vectors++;
    if (mdu_stall !== 1'b1) begin
      errors++;
      $display("FAIL overlap_stall: got %b want 1", mdu_stall);
    end
    tick();
    start = 1'b0; op = 4'd0;
    n = 2;
    while (busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    vectors++;
    if (n != 5) begin
      errors++;
      $display("FAIL overlap_cycles: got %0d want 5", n);
    end
    exp_v = sb_q.pop_front();
    vectors++;
    if ({hi, lo} !== exp_v) begin
      errors++;
      $display("FAIL overlap_result: got %h_%h want %h", hi, lo, exp_v);
    end
    mhl = exp_v;
  endtask

  task automatic test_cancel();
    op = 4'd1; rs_data = 32'd1234; rt_data = 32'd5678; start = 1'b1;
    tick();
    start = 1'b0; op = 4'd0;
    repeat (2) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    vectors++;
    if ({busy, hi, lo} !== {1'b0, mhl}) begin
      errors++;
      $display("FAIL cancel_run: got busy=%b %h_%h want busy=0 %h", busy, hi, lo, mhl);
    end
    repeat (6) tick();
    vectors++;
    if ({busy, hi, lo} !== {1'b0, mhl}) begin
      errors++;
      $display("FAIL cancel_later: got busy=%b %h_%h want busy=0 %h", busy, hi, lo, mhl);
    end
    op = 4'd2; rs_data = 32'd99; rt_data = 32'd77; start = 1'b1;
    tick();
    start = 1'b0; op = 4'd0;
    repeat (4) tick();
    vectors++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL cancel_last_busy: got %b want 1", busy);
    end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    vectors++;
    if ({busy, hi, lo} !== {1'b0, mhl}) begin
      errors++;
      $display("FAIL cancel_done_edge: got busy=%b %h_%h want busy=0 %h", busy, hi, lo, mhl);
    end
    op = 4'd9; rs_data = 32'hFFFF_0000; start = 1'b1; cancel = 1'b1;
    tick();
    op = 4'd1;
    tick();
    start = 1'b0; cancel = 1'b0; op = 4'd0;
    vectors++;
    if ({busy, hi, lo} !== {1'b0, mhl}) begin
      errors++;
      $display("FAIL cancel_idle: got busy=%b %h_%h want busy=0 %h", busy, hi, lo, mhl);
    end
    op = 4'd0; rs_data = 32'h1357_9BDF; start = 1'b1;
    tick();
    op = 4'd13;
    tick();
    start = 1'b0; op = 4'd0;
    vectors++;
    if ({busy, hi, lo} !== {1'b0, mhl}) begin
      errors++;
      $display("FAIL null_ops: got busy=%b %h_%h want busy=0 %h", busy, hi, lo, mhl);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_v;
    logic [63:0] m1;
    m1 = '0;
    sb_q.push_back(model(4'd1, 32'd3, 32'd4, m1));
    op1 = 4'd1; rs1 = 32'd3; rt1 = 32'd4; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    vectors++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_busy1: got %b want 1", busy1);
    end
    tick();
    exp_v = sb_q.pop_front();
    vectors++;
    if ({busy1, hi1, lo1} !== {1'b0, exp_v}) begin
      errors++;
      $display("FAIL b2b_first: got busy=%b %h_%h want busy=0 %h", busy1, hi1, lo1, exp_v);
    end
    m1 = exp_v;
    sb_q.push_back(model(4'd1, 32'd5, 32'd6, m1));
    op1 = 4'd1; rs1 = 32'd5; rt1 = 32'd6; start1 = 1'b1;
    tick();
    op1 = 4'd0; start1 = 1'b0;
    vectors++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b want 1", busy1);
    end
    tick();
    exp_v = sb_q.pop_front();
    vectors++;
    if ({busy1, hi1, lo1} !== {1'b0, exp_v}) begin
      errors++;
      $display("FAIL b2b_second: got busy=%b %h_%h want busy=0 %h", busy1, hi1, lo1, exp_v);
    end
    m1 = exp_v;
    sb_q.push_back(model(4'd3, 32'd100, 32'd7, m1));
    op1 = 4'd3; rs1 = 32'd100; rt1 = 32'd7; start1 = 1'b1;
    tick();
    op1 = 4'd0; start1 = 1'b0;
    tick();
    exp_v = sb_q.pop_front();
    vectors++;
    if ({busy1, hi1, lo1} !== {1'b0, exp_v}) begin
      errors++;
      $display("FAIL b2b_div: got busy=%b %h_%h want busy=0 %h", busy1, hi1, lo1, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_madd();
    test_overlap();
    test_cancel();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
